// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types, constants and helpers for the RV32M divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_DWIDTH = 32;
    localparam int DIV_ITER   = DIV_DWIDTH;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    function automatic logic is_signed_op(input div_op_t op);
        return ~op[0];
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module   : div_if
// Brief    : Request/response bundle between the execute stage and divider.
// Revision : 1.0 - initial release
// ============================================================================
interface div_if #(
    parameter int DWIDTH = 32
);
    logic              Div_Start;
    logic [1:0]        Div_Op;
    logic [DWIDTH-1:0] Div_Dividend;
    logic [DWIDTH-1:0] Div_Divisor;
    logic              Div_Busy;
    logic              Div_Done;
    logic [DWIDTH-1:0] Div_Result;

    modport master (
        output Div_Start, Div_Op, Div_Dividend, Div_Divisor,
        input  Div_Busy, Div_Done, Div_Result
    );

    modport slave (
        input  Div_Start, Div_Op, Div_Dividend, Div_Divisor,
        output Div_Busy, Div_Done, Div_Result
    );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One restoring-division step: shift, trial subtract, restore.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DWIDTH = 32
) (
    input  wire logic [DWIDTH-1:0] i_rem,
    input  wire logic [DWIDTH-1:0] i_quo,
    input  wire logic [DWIDTH-1:0] i_dsr,
    output logic      [DWIDTH-1:0] o_rem,
    output logic      [DWIDTH-1:0] o_quo
);

    logic [DWIDTH:0]   w_shift;
    logic [DWIDTH-1:0] w_diff;
    logic              w_ge;

    // Result of a successful subtract is below the divisor, so the low
    // DWIDTH bits of a modular subtract are exact.
    assign w_shift = {i_rem, i_quo[DWIDTH-1]};
    assign w_diff  = w_shift[DWIDTH-1:0] - i_dsr;
    assign w_ge    = w_shift[DWIDTH] | (w_shift[DWIDTH-1:0] >= i_dsr);

    assign o_rem = w_ge ? w_diff : w_shift[DWIDTH-1:0];
    assign o_quo = {i_quo[DWIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit
    import div_pkg::*;
#(
    parameter int DWIDTH = DIV_DWIDTH
) (
    input wire logic Clk,
    input wire logic Rst_N,
    div_if.slave     bus
);

    localparam int              CW       = $clog2(DWIDTH);
    localparam logic [CW-1:0]   CNT_INIT = CW'(DWIDTH - 1);
    localparam logic [DWIDTH-1:0] INT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    div_state_t        state_q, state_d;
    div_op_t           op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] rem_q, rem_d;
    logic [DWIDTH-1:0] quo_q, quo_d;
    logic [DWIDTH-1:0] dsr_q, dsr_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DWIDTH-1:0] w_step_rem;
    logic [DWIDTH-1:0] w_step_quo;
    div_op_t           w_op;
    logic [DWIDTH-1:0] w_a;
    logic [DWIDTH-1:0] w_b;
    logic              w_sgn;
    logic              w_div0;
    logic              w_ovf;

    div_step #(.DWIDTH(DWIDTH)) u_step (
        .i_rem (rem_q),
        .i_quo (quo_q),
        .i_dsr (dsr_q),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    assign w_op   = div_op_t'(bus.Div_Op);
    assign w_a    = bus.Div_Dividend;
    assign w_b    = bus.Div_Divisor;
    assign w_sgn  = is_signed_op(w_op);
    assign w_div0 = (w_b == '0);
    assign w_ovf  = w_sgn && (w_a == INT_MIN) && (w_b == '1);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        result_d = result_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.Div_Start) begin
                    op_d = w_op;
                    if (w_div0) begin
                        result_d = is_rem_op(w_op) ? w_a : '1;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else if (w_ovf) begin
                        result_d = is_rem_op(w_op) ? '0 : w_a;
                        state_d  = DONE;
                        done_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_INIT;
                        rem_d   = '0;
                        quo_d   = (w_sgn && w_a[DWIDTH-1]) ? -w_a : w_a;
                        dsr_d   = (w_sgn && w_b[DWIDTH-1]) ? -w_b : w_b;
                        qneg_d  = w_sgn & (w_a[DWIDTH-1] ^ w_b[DWIDTH-1]);
                        rneg_d  = w_sgn & w_a[DWIDTH-1];
                    end
                end
            end
            CALC: begin
                rem_d = w_step_rem;
                quo_d = w_step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                // Remainder follows the dividend sign; quotient follows sign XOR.
                if (is_rem_op(op_q)) begin
                    result_d = rneg_q ? -rem_q : rem_q;
                end else begin
                    result_d = qneg_q ? -quo_q : quo_q;
                end
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            result_q <= result_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.Div_Busy   = busy_q;
    assign bus.Div_Done   = done_q;
    assign bus.Div_Result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Scoreboard bench for div_unit with directed RV32M vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_pkg::*;

    logic Clk   = 1'b0;
    logic Rst_N = 1'b0;
    always #5 Clk = ~Clk;

    div_if #(.DWIDTH(32)) bus();

    div_unit #(.DWIDTH(32)) dut (
        .Clk   (Clk),
        .Rst_N (Rst_N),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (bus.Div_Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL spurious_done cyc=%0d got=%h expected no Done", cyc, bus.Div_Result);
            end else begin
                mon_e  = sb_q.pop_front();
                checks = checks + 1;
                if (bus.Div_Result !== mon_e.res) begin
                    errors = errors + 1;
                    $display("FAIL %s result got=%h expected=%h", mon_e.name, bus.Div_Result, mon_e.res);
                end
                checks = checks + 1;
                if (cyc != mon_e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL %s done_cycle got=%0d expected=%0d", mon_e.name, cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit track);
        bus.Div_Start    = 1'b1;
        bus.Div_Op       = op;
        bus.Div_Dividend = a;
        bus.Div_Divisor  = b;
        if (track) sb_q.push_back('{res: exp, cyc: cyc + lat, name: name});
        @(posedge Clk);
        #1 bus.Div_Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp, input int poke_at);
        bit ok_busy = 1'b1;
        bit ok_hold = 1'b1;
        bit seen    = 1'b0;
        int n_wait  = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge Clk);
            if (bus.Div_Done === 1'b1) begin
                seen = 1'b1;
                if (bus.Div_Busy !== 1'b0) ok_busy = 1'b0;
            end else begin
                n_wait++;
                if (bus.Div_Busy !== 1'b1) ok_busy = 1'b0;
                if (bus.Div_Result !== last_res) ok_hold = 1'b0;
                if (i == poke_at) begin
                    bus.Div_Start    = 1'b1;
                    bus.Div_Op       = 2'b00;
                    bus.Div_Dividend = 32'd1;
                    bus.Div_Divisor  = 32'd1;
                    @(posedge Clk);
                    #1 bus.Div_Start = 1'b0;
                end
            end
        end
        checks = checks + 1;
        if (!seen) begin
            errors = errors + 1;
            $display("FAIL %s timeout got=no_done expected=done within 100 cycles", name);
        end
        checks = checks + 1;
        if (!ok_busy) begin
            errors = errors + 1;
            $display("FAIL %s busy got=wrong level expected=1 while computing, 0 at done", name);
        end
        if (n_wait > 0) begin
            checks = checks + 1;
            if (!ok_hold) begin
                errors = errors + 1;
                $display("FAIL %s hold got=changed result expected=%h until done", name, last_res);
            end
        end
        last_res = exp;
    endtask

    task automatic go(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(negedge Clk);
        issue(name, op, a, b, exp, lat, 1'b1);
        wait_done(name, exp, -1);
    endtask

    initial begin
        bus.Div_Start    = 1'b0;
        bus.Div_Op       = 2'b00;
        bus.Div_Dividend = '0;
        bus.Div_Divisor  = '0;

        repeat (2) @(negedge Clk);
        chk("reset_busy",   {31'd0, bus.Div_Busy}, 32'd0);
        chk("reset_done",   {31'd0, bus.Div_Done}, 32'd0);
        chk("reset_result", bus.Div_Result,        32'd0);
        Rst_N = 1'b1;

        go("div_20_m3",   2'b00, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        go("div_m20_m3",  2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'h0000_0006, 34);
        go("rem_m20_m3",  2'b10, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34);
        go("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        go("remu_m7_2",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34);
        go("divu_m7_2",   2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34);
        go("divu_5_0",    2'b01, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        go("remu_5_0",    2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
        go("rem_m5_0",    2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1);
        go("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        go("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Back-to-back, with an ignored start pulse mid-computation.
        @(negedge Clk);
        issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        wait_done("divu_100_7", 32'd14, 5);
        issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 1'b1);
        wait_done("remu_100_7", 32'd2, -1);

        // Asynchronous abort in the middle of the iteration.
        @(negedge Clk);
        issue("div_abort", 2'b00, 32'd1000, 32'd3, 32'd0, 34, 1'b0);
        repeat (10) @(posedge Clk);
        #2 Rst_N = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, bus.Div_Busy}, 32'd0);
        chk("abort_done",   {31'd0, bus.Div_Done}, 32'd0);
        chk("abort_result", bus.Div_Result,        32'd0);
        chk("abort_state",  {30'd0, dut.state_q},  {30'd0, IDLE});
        repeat (3) @(negedge Clk);
        Rst_N    = 1'b1;
        last_res = '0;
        repeat (40) @(negedge Clk);
        chk("abort_idle_busy", {31'd0, bus.Div_Busy}, 32'd0);

        go("div_9_3", 2'b00, 32'd9, 32'd3, 32'd3, 34);

        repeat (3) @(negedge Clk);
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the ALU in the execute stage. Div_Result feeds the 2:1 result mux: input A is the ALU result, input B is Div_Result, and the select is the decoded is-divide flag.
- Div_Busy stalls the PC and register-file write until Div_Done pulses.

Parameters:
- DWIDTH, 32, operand and result width; must be even and >= 4.

Ports:
- Clk  in  1  core clock; all state updates on rising edge.
- Rst_N  in  1  asynchronous active-low reset.
- Div_Start  in  1  one-cycle request; sampled only in IDLE or DONE.
- Div_Op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; captured with Div_Start.
- Div_Dividend  in  DWIDTH  rs1 value; captured with Div_Start.
- Div_Divisor  in  DWIDTH  rs2 value; captured with Div_Start.
- Div_Busy  out  1  high from the edge that accepts Div_Start until the edge entering DONE.
- Div_Done  out  1  single-cycle pulse; Div_Result is valid in this cycle.
- Div_Result  out  DWIDTH  quotient or remainder per the captured op; held until the next accepted start.

Behaviour:
- Reset (async assert, sync deassert by clock domain): state=IDLE; Div_Busy, Div_Done, Div_Result, and all internal registers = 0. Reset in any state aborts the operation immediately, with no Div_Done.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE --Div_Start--> CALC (normal), or --Div_Start--> DONE (special case). Otherwise stay in IDLE.
- CALC: iteration counter loads DWIDTH-1 and decrements each cycle. When the counter is 0 and that step completes -> FIXUP. Exactly DWIDTH cycles are spent in CALC.
- FIXUP: sign correction, result select, Div_Result register load -> DONE.
- DONE: Div_Done=1 for one cycle. If Div_Start=1 in this cycle it is accepted (back-to-back) -> CALC or DONE. Otherwise -> IDLE.
- Div_Start in CALC or FIXUP is ignored, with no queuing.
- Normal latency: Div_Done is high in the cycle DWIDTH+2 edges after the accepting edge (34 for DWIDTH=32).
- Signed ops (DIV, REM):
  - Magnitudes are used internally.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Negation is two's complement, modulo 2^DWIDTH.
- Unsigned ops use the operands as-is.
- Datapath per step:
  - Partial remainder is DWIDTH+1 bits: {rem, q_msb} shifted left by 1.
  - Trial subtract divisor magnitude. If non-negative, keep the difference and shift a 1 into the quotient; else restore and shift a 0.
- Special case, divisor==0 (all ops): quotient = all ones; remainder = dividend (unmodified, original sign). Goes straight to DONE, so Div_Done is high in the cycle after the accepting edge.
- Special case, signed overflow (DIV/REM, dividend = 1 followed by DWIDTH-1 zeros, divisor = all ones): quotient = dividend, remainder = 0. Same 1-cycle fast path.
- Div_Result changes only on the edge entering DONE; it stays stable through IDLE, so the downstream mux sees a steady value.
- No exceptions are raised; all cases are RISC-V compliant.

Decomposition:
- Shared package div_pkg:
  - div_op_t enum (DIV, DIVU, REM, REMU, 2-bit).
  - div_state_t enum (IDLE, CALC, FIXUP, DONE).
  - Function is_signed_op.
  - Constant DIV_ITER = DWIDTH.
- One natural sub-module: div_step, purely combinational.
  - Inputs: partial remainder, quotient, divisor magnitude.
  - Outputs: next partial remainder and next quotient.
  - Isolates the subtract/restore logic for unit testing.
- FSM, operand capture, and sign fixup stay in div_unit.

Test Plan:
- DIV 20 / -3 (0x00000014, 0xFFFFFFFD) -> Div_Result=0xFFFFFFFA. Div_Done exactly 34 cycles after the accepting edge; Div_Busy high throughout CALC/FIXUP.
- REM -7 % 2 (0xFFFFFFF9, 0x00000002) -> 0xFFFFFFFF. Then REMU of the same operands -> 0x00000001 (0xFFFFFFF9 is odd); DIVU of the same -> 0x7FFFFFFC.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 % 0 -> 0x00000005. Div_Done in the cycle immediately after the accepting edge; Div_Busy never seen high in a CALC state.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same -> 0x00000000, both via the 1-cycle fast path.
- Back-to-back: DIVU 100/7 and assert Div_Start again in the Done cycle with REMU 100/7 -> results 14 then 2, with Done pulses 34 cycles apart. A Div_Start pulsed mid-CALC is ignored, and Div_Result is unchanged until the Done pulse.
- Deassert Rst_N asynchronously (mid-cycle) at iteration 10 of a DIV -> all outputs 0 immediately, state IDLE, no Done pulse. A fresh DIV 9/3 after reset release -> 3.
